// File: rtl/player_2_rx_ctrl.sv
// Receive-side framer for the remote player state link: decodes 7-byte
// A5-headed frames into registered player outputs and tracks link health.
module player_2_rx_ctrl #(
  parameter int unsigned BYTE_TIMEOUT = 65000,
  parameter int unsigned LINK_TIMEOUT = 6500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] player_2_x,
  output logic [11:0] player_2_y,
  output logic        player_2_flip_h,
  output logic [1:0]  player_2_class,
  output logic [3:0]  player_2_hp,
  output logic        player_2_data_valid,
  output logic        link_active,
  output logic [7:0]  frame_err_cnt
);

  localparam int unsigned GW = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned LW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(BYTE_TIMEOUT);
  localparam logic [LW-1:0] LINK_MAX = LW'(LINK_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    XH   = 3'd1,
    XL   = 3'd2,
    YH   = 3'd3,
    YL   = 3'd4,
    FL   = 3'd5,
    CK   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    xh_q, xh_d, xl_q, xl_d, yh_q, yh_d, yl_q, yl_d, fl_q, fl_d;
  logic [11:0]   x_q, x_d, y_q, y_d;
  logic          flip_q, flip_d;
  logic [1:0]    class_q, class_d;
  logic [3:0]    hp_q, hp_d;
  logic          dv_q, dv_d;
  logic [7:0]    err_q, err_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [LW-1:0] link_q, link_d;

  logic frame_ok;
  logic accept;
  logic reject;
  logic timeout;

  assign frame_ok = (rx_data == (xh_q ^ xl_q ^ yh_q ^ yl_q ^ fl_q)) &&
                    (xh_q[7:4] == 4'h0) && (yh_q[7:4] == 4'h0) &&
                    (fl_q[3:2] != 2'b00);

  always_comb begin
    state_d = state_q;
    xh_d    = xh_q;
    xl_d    = xl_q;
    yh_d    = yh_q;
    yl_d    = yl_q;
    fl_d    = fl_q;
    gap_d   = gap_q;
    accept  = 1'b0;
    reject  = 1'b0;
    timeout = 1'b0;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (rx_valid) begin
      gap_d = '0;
      unique case (state_q)
        IDLE: if (rx_data == 8'hA5) state_d = XH;
        XH: begin xh_d = rx_data; state_d = XL; end
        XL: begin xl_d = rx_data; state_d = YH; end
        YH: begin yh_d = rx_data; state_d = YL; end
        YL: begin yl_d = rx_data; state_d = FL; end
        FL: begin fl_d = rx_data; state_d = CK; end
        CK: begin
          state_d = IDLE;
          accept  = frame_ok;
          reject  = !frame_ok;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (gap_q == GAP_MAX) begin
        timeout = 1'b1;
        state_d = IDLE;
        gap_d   = '0;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end else begin
      gap_d = '0;
    end
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    flip_d  = flip_q;
    class_d = class_q;
    hp_d    = hp_q;
    dv_d    = accept;
    err_d   = err_q;
    link_d  = link_q;

    if (accept) begin
      x_d     = {xh_q[3:0], xl_q};
      y_d     = {yh_q[3:0], yl_q};
      flip_d  = fl_q[1];
      class_d = fl_q[3:2];
      hp_d    = fl_q[7:4];
    end

    if ((reject || timeout) && (err_q != 8'hFF)) err_d = err_q + 8'd1;

    if (accept) link_d = '0;
    else if (link_q != LINK_MAX) link_d = link_q + LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xh_q    <= '0;
      xl_q    <= '0;
      yh_q    <= '0;
      yl_q    <= '0;
      fl_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      flip_q  <= 1'b0;
      class_q <= '0;
      hp_q    <= '0;
      dv_q    <= 1'b0;
      err_q   <= '0;
      gap_q   <= '0;
      // Starting saturated keeps link_active low until the first good frame.
      link_q  <= LINK_MAX;
    end else begin
      state_q <= state_d;
      xh_q    <= xh_d;
      xl_q    <= xl_d;
      yh_q    <= yh_d;
      yl_q    <= yl_d;
      fl_q    <= fl_d;
      x_q     <= x_d;
      y_q     <= y_d;
      flip_q  <= flip_d;
      class_q <= class_d;
      hp_q    <= hp_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      link_q  <= link_d;
    end
  end

  assign player_2_x          = x_q;
  assign player_2_y          = y_q;
  assign player_2_flip_h     = flip_q;
  assign player_2_class      = class_q;
  assign player_2_hp         = hp_q;
  assign player_2_data_valid = dv_q;
  assign frame_err_cnt       = err_q;
  assign link_active         = (link_q != LINK_MAX);

endmodule
